wb_write_queue: RTL and testbench

- Writer-side companion to the processor register file: buffers writeback results from the ALU/execute path and drives the file's single write port (dst_reg, dst_data, write_en).
- Multi-cycle load results take a priority side path that is never back-pressured.
- Provides pending-write lookups so decode can stall on registers whose writes are still queued.

---
 rtl/wb_pkg.sv | 24 ++
 rtl/wb_entry_fifo.sv | 140 ++++++++++++++
 rtl/wb_write_queue.sv | 140 ++++++++++++++
 tb/tb_wb_write_queue.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths, entry type and constants for the writeback queue
//
// Purpose: default data/register-id widths, the default-width queue entry
// record and the hard-wired-zero register id used by wb_write_queue and
// wb_entry_fifo.
// Ports: none (package).

package wb_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_REG_ID_W = 4;

    // Register 0 reads as zero, so writes targeting it are dropped.
    localparam logic [DEF_REG_ID_W-1:0] REG_ZERO = '0;

    // Queue entry at default widths; wb_entry_fifo declares the same shape
    // locally so it can follow its own width parameters.
    typedef struct packed {
        logic                    valid;
        logic [DEF_REG_ID_W-1:0] reg_id;
        logic [DEF_DATA_W-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_entry_fifo.sv
// rtl/wb_entry_fifo.sv - compacting ring of pending writeback entries
//
// Purpose: DEPTH-entry ordered storage with per-entry valid, kill-by-id,
// head-skip of dead entries and pending-lookup match vectors.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   push, push_reg, push_data    append an entry at the tail
//   pop                          remove the head entry (ignored when empty)
//   kill_en, kill_reg            clear every live entry whose id matches
//   chk_reg1, chk_reg2           lookup ids
//   head_valid/head_reg/head_data  oldest live entry
//   full, count                  live-entry occupancy
//   kill_cnt                     entries killed at the coming edge
//   pend1, pend2                 lookup id has a live queued entry

module wb_entry_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int REG_ID_W = DEF_REG_ID_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [REG_ID_W-1:0]       push_reg,
    input  logic [DATA_W-1:0]         push_data,
    input  logic                      pop,
    input  logic                      kill_en,
    input  logic [REG_ID_W-1:0]       kill_reg,
    input  logic [REG_ID_W-1:0]       chk_reg1,
    input  logic [REG_ID_W-1:0]       chk_reg2,
    output logic                      head_valid,
    output logic [REG_ID_W-1:0]       head_reg,
    output logic [DATA_W-1:0]         head_data,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    count,
    output logic [$clog2(DEPTH):0]    kill_cnt,
    output logic                      pend1,
    output logic                      pend2
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic                valid;
        logic [REG_ID_W-1:0] reg_id;
        logic [DATA_W-1:0]   data;
    } entry_t;

    entry_t           mem   [DEPTH];
    entry_t           mem_n [DEPTH];
    entry_t           cur;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] head_n;
    logic [PTR_W-1:0] rd_idx;
    logic [PTR_W-1:0] wr_idx;
    logic [CNT_W-1:0] n_keep;
    logic [CNT_W-1:0] n_kill;
    logic             do_pop;
    logic             hit1;
    logic             hit2;

    // Live entries always sit contiguously from head (see compaction below),
    // so the tail is implicitly head + count and the head slot is live
    // whenever count is non-zero.
    assign head_valid = (count != '0);
    assign full       = (count == CNT_W'(DEPTH));
    assign do_pop     = pop && head_valid;
    assign head_reg   = mem[head].reg_id;
    assign head_data  = mem[head].data;
    assign kill_cnt   = n_kill;

    // Next-state: walk entries oldest-first, drop the popped head and any
    // killed entries, and repack the survivors from the new head. Killed
    // entries therefore vanish at the same edge and never cost an issue
    // cycle. The push lands after the survivors so a same-cycle kill can
    // never hit it.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_n[i] = '0;
        end
        head_n = head + PTR_W'(do_pop);
        n_keep = '0;
        n_kill = '0;
        rd_idx = head;
        wr_idx = head_n;
        cur    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            rd_idx = head + PTR_W'(k);
            cur    = mem[rd_idx];
            if (cur.valid) begin
                if (do_pop && (k == 0)) begin
                    n_keep = n_keep;
                end else if (kill_en && (cur.reg_id == kill_reg)) begin
                    n_kill = n_kill + 1'b1;
                end else begin
                    wr_idx        = head_n + PTR_W'(n_keep);
                    mem_n[wr_idx] = cur;
                    n_keep        = n_keep + 1'b1;
                end
            end
        end
        if (push) begin
            wr_idx        = head_n + PTR_W'(n_keep);
            mem_n[wr_idx] = '{valid: 1'b1, reg_id: push_reg, data: push_data};
            n_keep        = n_keep + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            head  <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= mem_n[i];
            end
            head  <= head_n;
            count <= n_keep;
        end
    end

    // Free slots always have valid cleared, so valid alone marks live entries.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i].valid && (mem[i].reg_id == chk_reg1)) hit1 = 1'b1;
            if (mem[i].valid && (mem[i].reg_id == chk_reg2)) hit2 = 1'b1;
        end
        pend1 = hit1 && (chk_reg1 != REG_ID_W'(REG_ZERO));
        pend2 = hit2 && (chk_reg2 != REG_ID_W'(REG_ZERO));
    end

endmodule

// File: rtl/wb_write_queue.sv
// rtl/wb_write_queue.sv - writeback queue driving the register file write port
//
// Purpose: buffers execute results, gives load results unconditional
// priority on the single write port, kills queued writes made stale by a
// load, and reports pending writes to decode.
// Optional: define WB_STATS_EN to add stat_writes, stat_kills and
// stat_full_cycles (16-bit saturating counters).
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   in_valid/in_ready/in_reg/in_data  execute result handshake
//   ld_valid/ld_reg/ld_data           load result, never back-pressured
//   write_en/dst_reg/dst_data         registered register file write port
//   chk_reg1/chk_reg2, pend1/pend2    decode pending-write lookups
//   count                             live queued entries

module wb_write_queue
    import wb_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int REG_ID_W = DEF_REG_ID_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [REG_ID_W-1:0]    in_reg,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   ld_valid,
    input  logic [REG_ID_W-1:0]    ld_reg,
    input  logic [DATA_W-1:0]      ld_data,
    output logic                   write_en,
    output logic [REG_ID_W-1:0]    dst_reg,
    output logic [DATA_W-1:0]      dst_data,
    input  logic [REG_ID_W-1:0]    chk_reg1,
    input  logic [REG_ID_W-1:0]    chk_reg2,
    output logic                   pend1,
    output logic                   pend2,
    output logic [$clog2(DEPTH):0] count
`ifdef WB_STATS_EN
    ,
    output logic [15:0]            stat_writes,
    output logic [15:0]            stat_kills,
    output logic [15:0]            stat_full_cycles
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                accept;
    logic                push;
    logic                ld_issue;
    logic                pop;
    logic                full;
    logic                head_valid;
    logic [REG_ID_W-1:0] head_reg;
    logic [DATA_W-1:0]   head_data;
    logic [CNT_W-1:0]    kill_cnt;

    // No pass-through when full: a pop in the same cycle does not open
    // in_ready, which keeps in_ready a pure function of registered state.
    assign in_ready = !full;
    assign accept   = in_valid && in_ready;
    // Writes to register 0 complete the handshake but are not stored.
    assign push     = accept && (in_reg != REG_ID_W'(REG_ZERO));
    assign ld_issue = ld_valid && (ld_reg != REG_ID_W'(REG_ZERO));
    assign pop      = head_valid && !ld_issue;

    // An issuing load is younger than everything queued, so it kills queued
    // writes to the same register rather than letting them overwrite it.
    wb_entry_fifo #(
        .DEPTH    (DEPTH),
        .DATA_W   (DATA_W),
        .REG_ID_W (REG_ID_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_reg   (in_reg),
        .push_data  (in_data),
        .pop        (pop),
        .kill_en    (ld_issue),
        .kill_reg   (ld_reg),
        .chk_reg1   (chk_reg1),
        .chk_reg2   (chk_reg2),
        .head_valid (head_valid),
        .head_reg   (head_reg),
        .head_data  (head_data),
        .full       (full),
        .count      (count),
        .kill_cnt   (kill_cnt),
        .pend1      (pend1),
        .pend2      (pend2)
    );

    // Idle cycles drop write_en but keep dst_reg/dst_data stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_en <= 1'b0;
            dst_reg  <= '0;
            dst_data <= '0;
        end else if (ld_issue) begin
            write_en <= 1'b1;
            dst_reg  <= ld_reg;
            dst_data <= ld_data;
        end else if (pop) begin
            write_en <= 1'b1;
            dst_reg  <= head_reg;
            dst_data <= head_data;
        end else begin
            write_en <= 1'b0;
        end
    end

`ifdef WB_STATS_EN
    logic [16:0] kill_sum;

    assign kill_sum = {1'b0, stat_kills} + 17'(kill_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_writes      <= '0;
            stat_kills       <= '0;
            stat_full_cycles <= '0;
        end else begin
            if (write_en && (stat_writes != 16'hFFFF)) begin
                stat_writes <= stat_writes + 16'd1;
            end
            stat_kills <= kill_sum[16] ? 16'hFFFF : kill_sum[15:0];
            if (in_valid && !in_ready && (stat_full_cycles != 16'hFFFF)) begin
                stat_full_cycles <= stat_full_cycles + 16'd1;
            end
        end
    end
`else
    logic stats_unused;
    assign stats_unused = ^kill_cnt;
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// tb/tb_wb_write_queue.sv - scoreboard bench for wb_write_queue

module tb_wb_write_queue;

    localparam int DEPTH    = 4;
    localparam int DATA_W   = 16;
    localparam int REG_ID_W = 4;
    localparam int CNT_W    = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [REG_ID_W-1:0] in_reg;
    logic [DATA_W-1:0]   in_data;
    logic                ld_valid;
    logic [REG_ID_W-1:0] ld_reg;
    logic [DATA_W-1:0]   ld_data;
    logic                write_en;
    logic [REG_ID_W-1:0] dst_reg;
    logic [DATA_W-1:0]   dst_data;
    logic [REG_ID_W-1:0] chk_reg1;
    logic [REG_ID_W-1:0] chk_reg2;
    logic                pend1;
    logic                pend2;
    logic [CNT_W-1:0]    count;
`ifdef WB_STATS_EN
    logic [15:0]         stat_writes;
    logic [15:0]         stat_kills;
    logic [15:0]         stat_full_cycles;
`endif

    typedef struct packed {
        logic [REG_ID_W-1:0] r;
        logic [DATA_W-1:0]   d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_w;
    int  vectors     = 0;
    int  miscompares = 0;

    wb_write_queue #(
        .DEPTH    (DEPTH),
        .DATA_W   (DATA_W),
        .REG_ID_W (REG_ID_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_reg   (in_reg),
        .in_data  (in_data),
        .ld_valid (ld_valid),
        .ld_reg   (ld_reg),
        .ld_data  (ld_data),
        .write_en (write_en),
        .dst_reg  (dst_reg),
        .dst_data (dst_data),
        .chk_reg1 (chk_reg1),
        .chk_reg2 (chk_reg2),
        .pend1    (pend1),
        .pend2    (pend2),
        .count    (count)
`ifdef WB_STATS_EN
        ,
        .stat_writes      (stat_writes),
        .stat_kills       (stat_kills),
        .stat_full_cycles (stat_full_cycles)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every register file write must be the next expected one.
    always @(negedge clk) begin
        if (write_en === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got reg=%0d data=%h, required no write", dst_reg, dst_data);
            end else begin
                mon_w = exp_q.pop_front();
                if (dst_reg !== mon_w.r || dst_data !== mon_w.d) begin
                    miscompares++;
                    $display("FAIL write_order: got reg=%0d data=%h, required reg=%0d data=%h",
                             dst_reg, dst_data, mon_w.r, mon_w.d);
                end
            end
        end
    end

    function automatic wr_t mk(input int r, input int d);
        mk.r = REG_ID_W'(r);
        mk.d = DATA_W'(d);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_reg   = '0;
        in_data  = '0;
        ld_valid = 1'b0;
        ld_reg   = '0;
        ld_data  = '0;
    endtask

    task automatic drain(output bit done);
        done = 1'b0;
        for (int t = 0; t < 30 && !done; t++) begin
            step();
            if (count == '0 && write_en === 1'b0 && exp_q.size() == 0) done = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        chk_reg1 = '0;
        chk_reg2 = '0;
        step();
        step();
        vectors++;
        if (write_en !== 1'b0 || dst_reg !== '0 || dst_data !== '0 || count !== '0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state: got we=%b reg=%0d data=%h count=%0d ready=%b, required 0 0 0000 0 1",
                     write_en, dst_reg, dst_data, count, in_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        bit done;
        in_valid = 1'b1;
        in_reg   = 4'd3;
        in_data  = 16'h1234;
        exp_q.push_back(mk(3, 'h1234));
        step();
        idle();
        vectors++;
        if (write_en !== 1'b0 || count !== 3'd1) begin
            miscompares++;
            $display("FAIL basic_accept: got we=%b count=%0d, required we=0 count=1", write_en, count);
        end
        step();
        vectors++;
        if (write_en !== 1'b1 || dst_reg !== 4'd3 || dst_data !== 16'h1234 || count !== '0) begin
            miscompares++;
            $display("FAIL basic_issue: got we=%b reg=%0d data=%h count=%0d, required 1 3 1234 0",
                     write_en, dst_reg, dst_data, count);
        end
        drain(done);
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL basic_drain: got count=%0d pending=%0d, required 0 0", count, exp_q.size());
        end
    endtask

    task automatic test_full_load();
        bit done;
        bit accepted;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1;
            in_reg   = REG_ID_W'(i + 1);
            in_data  = DATA_W'(16'h1000 + i);
            ld_valid = 1'b1;
            ld_reg   = REG_ID_W'(5 + i);
            ld_data  = DATA_W'(16'h5000 + i);
            exp_q.push_back(mk(5 + i, 16'h5000 + i));
            step();
            vectors++;
            if (count !== CNT_W'(i + 1)) begin
                miscompares++;
                $display("FAIL full_fill_count: got %0d, required %0d", count, i + 1);
            end
        end
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_ready: got in_ready=%b, required 0", in_ready);
        end
        in_reg  = 4'd10;
        in_data = 16'hA0A0;
        ld_reg  = 4'd9;
        ld_data = 16'h9999;
        exp_q.push_back(mk(9, 'h9999));
        step();
        vectors++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_stall: got count=%0d ready=%b, required 4 0", count, in_ready);
        end
        ld_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(mk(i + 1, 16'h1000 + i));
        exp_q.push_back(mk(10, 'hA0A0));
        accepted = 1'b0;
        for (int t = 0; t < 10 && !accepted; t++) begin
            accepted = in_ready;
            step();
        end
        in_valid = 1'b0;
        vectors++;
        if (!accepted) begin
            miscompares++;
            $display("FAIL full_resume: got no acceptance, required acceptance");
        end
        drain(done);
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL full_drain: got count=%0d pending=%0d, required 0 0", count, exp_q.size());
        end
    endtask

    task automatic test_collision();
        bit done;
        in_valid = 1'b1; in_reg = 4'd5; in_data = 16'hAAAA;
        ld_valid = 1'b1; ld_reg = 4'd6; ld_data = 16'h6666;
        exp_q.push_back(mk(6, 'h6666));
        step();
        in_reg = 4'd7; in_data = 16'h7777;
        ld_data = 16'h6667;
        exp_q.push_back(mk(6, 'h6667));
        step();
        vectors++;
        if (count !== 3'd2) begin
            miscompares++;
            $display("FAIL coll_prefill: got count=%0d, required 2", count);
        end
        in_reg = 4'd5; in_data = 16'hCCCC;
        ld_reg = 4'd5; ld_data = 16'hBBBB;
        exp_q.push_back(mk(5, 'hBBBB));
        exp_q.push_back(mk(7, 'h7777));
        exp_q.push_back(mk(5, 'hCCCC));
        step();
        idle();
        vectors++;
        if (count !== 3'd2) begin
            miscompares++;
            $display("FAIL coll_kill_count: got count=%0d, required 2", count);
        end
`ifdef WB_STATS_EN
        vectors++;
        if (stat_kills !== 16'd1) begin
            miscompares++;
            $display("FAIL coll_stat_kills: got %0d, required 1", stat_kills);
        end
`endif
        drain(done);
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL coll_drain: got count=%0d pending=%0d, required 0 0", count, exp_q.size());
        end
    endtask

    task automatic test_zero_regs();
        bit done;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_reg = '0; in_data = 16'hFFFF;
            ld_valid = 1'b1; ld_reg = '0; ld_data = 16'hEEEE;
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL zero_ready: got in_ready=%b, required 1", in_ready);
            end
            step();
            vectors++;
            if (write_en !== 1'b0 || count !== '0) begin
                miscompares++;
                $display("FAIL zero_no_write: got we=%b count=%0d, required 0 0", write_en, count);
            end
        end
        in_reg = 4'd2; in_data = 16'h2222;
        step();
        in_valid = 1'b0;
        exp_q.push_back(mk(2, 'h2222));
        step();
        vectors++;
        if (write_en !== 1'b1 || dst_reg !== 4'd2) begin
            miscompares++;
            $display("FAIL zero_ld_pop: got we=%b reg=%0d, required 1 2", write_en, dst_reg);
        end
        idle();
        drain(done);
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL zero_drain: got count=%0d pending=%0d, required 0 0", count, exp_q.size());
        end
    endtask

    task automatic test_pending();
        bit done;
        in_valid = 1'b1; in_reg = 4'd9; in_data = 16'h0909;
        ld_valid = 1'b1; ld_reg = 4'd4; ld_data = 16'h4444;
        exp_q.push_back(mk(4, 'h4444));
        step();
        in_valid = 1'b0;
        ld_data  = 16'h4445;
        exp_q.push_back(mk(4, 'h4445));
        chk_reg1 = 4'd9;
        chk_reg2 = 4'd0;
        #1;
        vectors++;
        if (pend1 !== 1'b1 || pend2 !== 1'b0) begin
            miscompares++;
            $display("FAIL pend_queued: got pend1=%b pend2=%b, required 1 0", pend1, pend2);
        end
        chk_reg2 = 4'd3;
        #1;
        vectors++;
        if (pend2 !== 1'b0) begin
            miscompares++;
            $display("FAIL pend_other: got pend2=%b, required 0", pend2);
        end
        step();
        ld_valid = 1'b0;
        exp_q.push_back(mk(9, 'h0909));
        step();
        vectors++;
        if (pend1 !== 1'b0 || write_en !== 1'b1 || dst_reg !== 4'd9) begin
            miscompares++;
            $display("FAIL pend_issued: got pend1=%b we=%b reg=%0d, required 0 1 9", pend1, write_en, dst_reg);
        end
        chk_reg1 = '0;
        chk_reg2 = '0;
        idle();
        drain(done);
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL pend_drain: got count=%0d pending=%0d, required 0 0", count, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        bit done;
        int d;
        for (int i = 0; i < 8; i++) begin
            d        = int'($urandom_range(0, 16'hFFFF));
            in_valid = 1'b1;
            in_reg   = REG_ID_W'((i % 15) + 1);
            in_data  = DATA_W'(d);
            exp_q.push_back(mk((i % 15) + 1, d));
            step();
            vectors++;
            if (count !== 3'd1) begin
                miscompares++;
                $display("FAIL b2b_count: got %0d, required 1", count);
            end
        end
        idle();
        drain(done);
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL b2b_drain: got count=%0d pending=%0d, required 0 0", count, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_reg = REG_ID_W'(i + 1); in_data = DATA_W'(16'h3300 + i);
            ld_valid = 1'b1; ld_reg = REG_ID_W'(10 + i); ld_data = DATA_W'(16'hD000 + i);
            exp_q.push_back(mk(10 + i, 16'hD000 + i));
            step();
        end
        vectors++;
        if (count !== 3'd3) begin
            miscompares++;
            $display("FAIL rstmid_fill: got count=%0d, required 3", count);
        end
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if (write_en !== 1'b0 || count !== '0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_state: got we=%b count=%0d ready=%b, required 0 0 1", write_en, count, in_ready);
        end
        for (int t = 0; t < 6; t++) begin
            step();
            vectors++;
            if (write_en !== 1'b0) begin
                miscompares++;
                $display("FAIL rstmid_no_write: got we=%b reg=%0d, required 0", write_en, dst_reg);
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL rstmid_scoreboard: got %0d outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_load();
        test_collision();
        test_zero_regs();
        test_pending();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
